// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: blocking, single-outstanding line-read controller in front of the cache array.
// A request is looked up in the array. A hit returns the selected entry. A miss fetches the line
// from the next level, installs it into the way the array nominated, and returns the fetched line.
module cache_miss_ctrl #(
  parameter int unsigned SETS           = 32,
  parameter int unsigned WAYS           = 4,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned CACHELINE_SIZE = 64,
  parameter int unsigned BANK_TYPE      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  // pipeline request
  input  logic                      i_req_vld,
  output logic                      o_req_rdy,
  input  logic [ADDR_WIDTH-1:0]     i_req_addr,
  // pipeline response
  output logic                      o_resp_vld,
  input  logic                      i_resp_rdy,
  output logic [CACHELINE_SIZE-1:0] o_resp_data,
  output logic                      o_resp_miss,
  // array lookup port
  output logic                      o_lookup_req,
  input  logic                      i_lookup_gnt,
  output logic [ADDR_WIDTH-1:0]     o_lookup_addr,
  input  logic                      i_lookup_hit,
  input  logic                      i_lookup_hit_rdy,
  input  logic [WAYS-1:0]           i_lookup_sel_vec,
  input  logic [CACHELINE_SIZE-1:0] i_lookup_data,
  // array write port
  output logic                      o_write_req,
  output logic [ADDR_WIDTH-1:0]     o_write_addr,
  output logic [WAYS-1:0]           o_write_way_vec,
  output logic [CACHELINE_SIZE-1:0] o_write_data,
  // next-level memory
  output logic                      o_mem_req_vld,
  input  logic                      i_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]     o_mem_req_addr,
  input  logic                      i_mem_resp_vld,
  input  logic [CACHELINE_SIZE-1:0] i_mem_resp_data
);

  // Offset and bank bits below the set index are dropped for the refill address.
  localparam int unsigned LineOffW = $clog2(CACHELINE_SIZE) + BANK_TYPE;
  localparam logic [ADDR_WIDTH-1:0] LineMask = {ADDR_WIDTH{1'b1}} << LineOffW;

  // The array indexes sets by address bits, so a non power-of-two set count cannot match it.
  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_sets_chk
    $error("cache_miss_ctrl: SETS must be a power of two");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StTagchk,
    StData,
    StMemreq,
    StMemwait,
    StRefill,
    StResp
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [WAYS-1:0]           way_q, way_d;
  logic                      hit_q, hit_d;
  logic [CACHELINE_SIZE-1:0] data_q, data_d;
  logic                      resp_miss_q, resp_miss_d;

  // Next-state logic: each state owns the registers it latches; everything else holds.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    way_d       = way_q;
    hit_d       = hit_q;
    data_d      = data_q;
    resp_miss_d = resp_miss_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_vld) begin
          addr_d  = i_req_addr;
          state_d = StLookup;
        end
      end
      StLookup: begin
        // A denied grant only delays us; we never write while looking up.
        if (i_lookup_gnt) state_d = StTagchk;
      end
      StTagchk: begin
        hit_d   = i_lookup_hit;
        way_d   = i_lookup_sel_vec;
        state_d = StData;
      end
      StData: begin
        // On a miss this is the victim entry; write-through means it is simply overwritten.
        data_d = i_lookup_data;
        if (hit_q) begin
          resp_miss_d = 1'b0;
          state_d     = StResp;
        end else begin
          state_d = StMemreq;
        end
      end
      StMemreq: begin
        if (i_mem_req_rdy) state_d = StMemwait;
      end
      StMemwait: begin
        if (i_mem_resp_vld) begin
          data_d  = i_mem_resp_data;
          state_d = StRefill;
        end
      end
      StRefill: begin
        resp_miss_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (i_resp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      way_q       <= '0;
      hit_q       <= 1'b0;
      data_q      <= '0;
      resp_miss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      way_q       <= way_d;
      hit_q       <= hit_d;
      data_q      <= data_d;
      resp_miss_q <= resp_miss_d;
    end
  end

  // Outputs are pure decodes of registered state; data buses are zero outside their state.
  always_comb begin
    o_req_rdy       = (state_q == StIdle);
    o_lookup_req    = (state_q == StLookup);
    o_lookup_addr   = addr_q;
    o_mem_req_vld   = (state_q == StMemreq);
    o_mem_req_addr  = addr_q & LineMask;
    o_write_req     = (state_q == StRefill);
    o_write_addr    = addr_q;
    o_write_way_vec = (state_q == StRefill) ? way_q  : '0;
    o_write_data    = (state_q == StRefill) ? data_q : '0;
    o_resp_vld      = (state_q == StResp);
    o_resp_data     = (state_q == StResp) ? data_q : '0;
    o_resp_miss     = (state_q == StResp) ? resp_miss_q : 1'b0;
  end

  // The array must present its tag result in the cycle after the grant.
  a_tag_rdy: assert property (@(posedge clk) disable iff (rst)
    (state_q == StTagchk) |-> i_lookup_hit_rdy);

  // Install exactly one way.
  a_way_onehot: assert property (@(posedge clk) disable iff (rst)
    (state_q == StRefill) |-> $onehot(way_q));

  a_no_rw_overlap: assert property (@(posedge clk) disable iff (rst)
    !(o_lookup_req && o_write_req));

  // A refill beat outside the wait state is dropped; flag it without stopping the run.
  a_stray_mem_resp: assert property (@(posedge clk) disable iff (rst)
    i_mem_resp_vld |-> (state_q == StMemwait))
    else $warning("cache_miss_ctrl: stray memory response ignored in state %0d", state_q);

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl with a small behavioural array model.
// Array entry format used here: [63] vld, [47:32] tag = addr[27:12], [31:0] payload.
module tb_cache_miss_ctrl;
  localparam int unsigned AW = 64;
  localparam int unsigned LW = 64;

  localparam logic [AW-1:0] HIT_ADDR   = 64'h0000_0000_0123_41A4;  // set 3, tag 0x1234
  localparam logic [LW-1:0] HIT_ENT    = 64'h8000_1234_CAFE_0003;
  localparam logic [AW-1:0] MISS_ADDR  = 64'h0000_0000_0BEE_F2C5;  // set 5, tag 0xBEEF
  localparam logic [AW-1:0] MISS_ALIGN = 64'h0000_0000_0BEE_F280;
  localparam logic [LW-1:0] MISS_ENT   = 64'h8000_BEEF_1234_5678;
  localparam logic [AW-1:0] MS_ADDR    = 64'h0000_0000_0077_7391;  // set 7, tag 0x0777
  localparam logic [AW-1:0] MS_ALIGN   = 64'h0000_0000_0077_7380;
  localparam logic [LW-1:0] MS_ENT     = 64'h8000_0777_0BAD_F00D;
  localparam logic [AW-1:0] RST_ADDR   = 64'h0000_0000_0099_9480;  // set 9, tag 0x0999
  localparam logic [LW-1:0] JUNK       = 64'hDEAD_DEAD_DEAD_DEAD;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_vld, o_req_rdy;
  logic [AW-1:0] i_req_addr;
  logic          o_resp_vld, i_resp_rdy, o_resp_miss;
  logic [LW-1:0] o_resp_data;
  logic          o_lookup_req, i_lookup_gnt;
  logic [AW-1:0] o_lookup_addr;
  logic          i_lookup_hit, i_lookup_hit_rdy;
  logic [3:0]    i_lookup_sel_vec;
  logic [LW-1:0] i_lookup_data;
  logic          o_write_req;
  logic [AW-1:0] o_write_addr;
  logic [3:0]    o_write_way_vec;
  logic [LW-1:0] o_write_data;
  logic          o_mem_req_vld, i_mem_req_rdy;
  logic [AW-1:0] o_mem_req_addr;
  logic          i_mem_resp_vld;
  logic [LW-1:0] i_mem_resp_data;

  always #5 clk = ~clk;

  cache_miss_ctrl #(
    .SETS(32), .WAYS(4), .ADDR_WIDTH(AW), .CACHELINE_SIZE(LW), .BANK_TYPE(1)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_vld        (i_req_vld),
    .o_req_rdy        (o_req_rdy),
    .i_req_addr       (i_req_addr),
    .o_resp_vld       (o_resp_vld),
    .i_resp_rdy       (i_resp_rdy),
    .o_resp_data      (o_resp_data),
    .o_resp_miss      (o_resp_miss),
    .o_lookup_req     (o_lookup_req),
    .i_lookup_gnt     (i_lookup_gnt),
    .o_lookup_addr    (o_lookup_addr),
    .i_lookup_hit     (i_lookup_hit),
    .i_lookup_hit_rdy (i_lookup_hit_rdy),
    .i_lookup_sel_vec (i_lookup_sel_vec),
    .i_lookup_data    (i_lookup_data),
    .o_write_req      (o_write_req),
    .o_write_addr     (o_write_addr),
    .o_write_way_vec  (o_write_way_vec),
    .o_write_data     (o_write_data),
    .o_mem_req_vld    (o_mem_req_vld),
    .i_mem_req_rdy    (i_mem_req_rdy),
    .o_mem_req_addr   (o_mem_req_addr),
    .i_mem_resp_vld   (i_mem_resp_vld),
    .i_mem_resp_data  (i_mem_resp_data)
  );

  // ---------------- array model: tag result 1 cycle, data 2 cycles after grant ----------------
  logic [LW-1:0] arr [32][4];
  logic [3:0]    victim;
  logic          p1_vld, p1_hit;
  logic [3:0]    p1_sel;
  logic [LW-1:0] p1_ent, p2_ent;

  function automatic logic [68:0] model_lookup(input logic [AW-1:0] a, input logic [3:0] vic);
    logic          h;
    logic [3:0]    sv;
    logic [LW-1:0] e;
    h  = 1'b0;
    sv = vic;
    e  = '0;
    for (int w = 0; w < 4; w++) if (vic[w]) e = arr[a[11:7]][w];
    for (int w = 0; w < 4; w++) begin
      if (arr[a[11:7]][w][63] && arr[a[11:7]][w][47:32] == a[27:12]) begin
        h  = 1'b1;
        sv = 4'(1 << w);
        e  = arr[a[11:7]][w];
      end
    end
    return {h, sv, e};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) for (int w = 0; w < 4; w++) arr[i][w] <= '0;
      arr[3][2] <= HIT_ENT;
      p1_vld <= 1'b0;
      p1_hit <= 1'b0;
      p1_sel <= '0;
      p1_ent <= '0;
      p2_ent <= '0;
    end else begin
      p1_vld                   <= o_lookup_req && i_lookup_gnt;
      {p1_hit, p1_sel, p1_ent} <= model_lookup(o_lookup_addr, victim);
      p2_ent                   <= p1_ent;
      if (o_write_req)
        for (int w = 0; w < 4; w++)
          if (o_write_way_vec[w]) arr[o_write_addr[11:7]][w] <= o_write_data;
    end
  end

  assign i_lookup_hit_rdy = p1_vld;
  assign i_lookup_hit     = p1_hit;
  assign i_lookup_sel_vec = p1_sel;
  assign i_lookup_data    = p2_ent;

  // ---------------- passive monitor ----------------
  int            wr_cnt = 0, mvld_cyc = 0, overlap = 0;
  logic [3:0]    wr_way = '0;
  logic [LW-1:0] wr_data = '0;
  logic [AW-1:0] wr_addr = '0, mreq_addr = '0;

  always @(posedge clk) begin
    if (o_write_req) begin
      wr_cnt  <= wr_cnt + 1;
      wr_way  <= o_write_way_vec;
      wr_data <= o_write_data;
      wr_addr <= o_write_addr;
    end
    if (o_mem_req_vld) mvld_cyc <= mvld_cyc + 1;
    if (o_mem_req_vld && i_mem_req_rdy) mreq_addr <= o_mem_req_addr;
    if (o_lookup_req && o_write_req) overlap <= overlap + 1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int lk_cnt, lk_bad, hold_bad;

  // Issue one request from IDLE (called at a negedge) and drive grant/memory per cycle.
  // lat counts cycles from the accept cycle (0) to the first cycle o_resp_vld is seen.
  task automatic run_req(input logic [AW-1:0] addr, input int gnt_stall, input int rdy_wait,
                         input int resp_lat, input bit spurious, input logic [LW-1:0] mem_ent,
                         input int rsp_hold, output int lat, output logic [LW-1:0] rdata,
                         output logic rmiss);
    int k, mreq_seen, hs;
    k = 0; mreq_seen = 0; hs = -1;
    lk_cnt = 0; lk_bad = 0; hold_bad = 0;
    i_req_vld = 1'b1; i_req_addr = addr; i_lookup_gnt = 1'b0;
    i_mem_req_rdy = 1'b0; i_mem_resp_vld = 1'b0; i_resp_rdy = 1'b0;
    @(negedge clk);
    k = 1;
    i_req_vld = 1'b0;
    while (!o_resp_vld && k < 100) begin
      if (o_lookup_req) begin
        lk_cnt++;
        if (o_lookup_addr !== addr) lk_bad++;
      end
      i_lookup_gnt    = (k > gnt_stall);
      i_mem_req_rdy   = 1'b0;
      i_mem_resp_vld  = 1'b0;
      i_mem_resp_data = '0;
      if (o_mem_req_vld) begin
        mreq_seen++;
        if (mreq_seen > rdy_wait) begin
          i_mem_req_rdy = 1'b1;
          hs = k;
        end else if (spurious && mreq_seen == 2) begin
          i_mem_resp_vld  = 1'b1;
          i_mem_resp_data = JUNK;
        end
      end else if (hs >= 0 && k == hs + resp_lat) begin
        i_mem_resp_vld  = 1'b1;
        i_mem_resp_data = mem_ent;
      end
      @(negedge clk);
      k++;
    end
    i_lookup_gnt = 1'b0; i_mem_req_rdy = 1'b0; i_mem_resp_vld = 1'b0;
    check_eq("resp_seen", o_resp_vld, 1);
    lat   = k;
    rdata = o_resp_data;
    rmiss = o_resp_miss;
    for (int h = 0; h < rsp_hold; h++) begin
      @(negedge clk);
      if (o_resp_vld !== 1'b1 || o_resp_miss !== rmiss || o_resp_data !== rdata ||
          o_req_rdy !== 1'b0) hold_bad++;
    end
    i_resp_rdy = 1'b1;
    @(negedge clk);
    i_resp_rdy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int            lat, wr0, mv0;
    logic [LW-1:0] rd;
    logic          rm;
    rst = 1'b1; i_req_vld = 1'b0; i_req_addr = '0; i_resp_rdy = 1'b0; i_lookup_gnt = 1'b0;
    i_mem_req_rdy = 1'b0; i_mem_resp_vld = 1'b0; i_mem_resp_data = '0; victim = 4'b0001;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_req_rdy", o_req_rdy, 1);
    check_eq("rst_lookup_req", o_lookup_req, 0);
    check_eq("rst_outs", {o_write_req, o_mem_req_vld, o_resp_vld, o_resp_miss}, 0);
    check_eq("rst_resp_data", o_resp_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Hit on the preloaded entry
    wr0 = wr_cnt; mv0 = mvld_cyc;
    run_req(HIT_ADDR, 0, 0, 0, 1'b0, '0, 0, lat, rd, rm);
    check_eq("hit_lat", lat, 4);
    check_eq("hit_miss", rm, 0);
    check_eq("hit_data", rd, HIT_ENT);
    check_eq("hit_no_write", wr_cnt - wr0, 0);
    check_eq("hit_no_memreq", mvld_cyc - mv0, 0);
    check_eq("hit_req_rdy_after", o_req_rdy, 1);

    // Miss with victim way 1, memory answers 5 cycles after the request
    victim = 4'b0010;
    wr0 = wr_cnt; mv0 = mvld_cyc;
    run_req(MISS_ADDR, 0, 0, 5, 1'b0, MISS_ENT, 0, lat, rd, rm);
    check_eq("miss_lat", lat, 11);
    check_eq("miss_flag", rm, 1);
    check_eq("miss_data", rd, MISS_ENT);
    check_eq("miss_mem_addr", mreq_addr, MISS_ALIGN);
    check_eq("miss_write_cnt", wr_cnt - wr0, 1);
    check_eq("miss_write_way", wr_way, 4'b0010);
    check_eq("miss_write_data", wr_data, MISS_ENT);
    check_eq("miss_write_addr", wr_addr, MISS_ADDR);

    // Same address now hits; a different victim proves the hit way is used
    victim = 4'b0001;
    wr0 = wr_cnt;
    run_req(MISS_ADDR, 0, 0, 0, 1'b0, '0, 0, lat, rd, rm);
    check_eq("rehit_lat", lat, 4);
    check_eq("rehit_miss", rm, 0);
    check_eq("rehit_data", rd, MISS_ENT);
    check_eq("rehit_no_write", wr_cnt - wr0, 0);

    // Grant withheld for 3 cycles
    run_req(HIT_ADDR, 3, 0, 0, 1'b0, '0, 0, lat, rd, rm);
    check_eq("stall_lat", lat, 7);
    check_eq("stall_lookup_cycles", lk_cnt, 4);
    check_eq("stall_addr_stable", lk_bad, 0);
    check_eq("stall_data", rd, HIT_ENT);

    // Memory back-pressure plus a stray beat during MEMREQ
    victim = 4'b1000;
    wr0 = wr_cnt; mv0 = mvld_cyc;
    run_req(MS_ADDR, 0, 4, 2, 1'b1, MS_ENT, 0, lat, rd, rm);
    check_eq("mstall_lat", lat, 12);
    check_eq("mstall_memreq_cycles", mvld_cyc - mv0, 5);
    check_eq("mstall_mem_addr", mreq_addr, MS_ALIGN);
    check_eq("mstall_write_cnt", wr_cnt - wr0, 1);
    check_eq("mstall_write_way", wr_way, 4'b1000);
    check_eq("mstall_write_data", wr_data, MS_ENT);
    check_eq("mstall_resp_data", rd, MS_ENT);
    check_eq("mstall_resp_miss", rm, 1);

    // Response back-pressure for 5 cycles
    run_req(HIT_ADDR, 0, 0, 0, 1'b0, '0, 5, lat, rd, rm);
    check_eq("bp_lat", lat, 4);
    check_eq("bp_stable", hold_bad, 0);
    check_eq("bp_data", rd, HIT_ENT);
    check_eq("bp_req_rdy_after", o_req_rdy, 1);

    // Reset while waiting for memory
    victim = 4'b0100;
    wr0 = wr_cnt;
    i_req_vld = 1'b1; i_req_addr = RST_ADDR; i_lookup_gnt = 1'b1;
    @(negedge clk);
    i_req_vld = 1'b0;
    for (int i = 0; i < 20 && !o_mem_req_vld; i++) @(negedge clk);
    check_eq("rst_reach_memreq", o_mem_req_vld, 1);
    i_mem_req_rdy = 1'b1;
    @(negedge clk);
    i_mem_req_rdy = 1'b0;
    check_eq("rst_in_memwait", {o_mem_req_vld, o_req_rdy, o_resp_vld}, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_mem_resp_vld = 1'b1; i_mem_resp_data = JUNK;
    check_eq("rst_mid_req_rdy", o_req_rdy, 1);
    check_eq("rst_mid_ctrl",
             {o_lookup_req, o_write_req, o_mem_req_vld, o_resp_vld, o_resp_miss}, 0);
    check_eq("rst_mid_resp_data", o_resp_data, 0);
    check_eq("rst_mid_write_data", o_write_data, 0);
    check_eq("rst_mid_write_way", o_write_way_vec, 0);
    check_eq("rst_mid_mem_addr", o_mem_req_addr, 0);
    @(negedge clk);
    i_mem_resp_vld = 1'b0; i_mem_resp_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_mid_no_write", wr_cnt - wr0, 0);
    check_eq("rst_mid_idle", o_req_rdy, 1);
    check_eq("rst_mid_quiet", {o_write_req, o_lookup_req, o_resp_vld}, 0);

    check_eq("no_lookup_write_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
